// File: rtl/cell_cache_pkg.sv
// Shared types and constants for the cell cache arbiter.
// FSM encoding, default geometry and stall counter width.
package cell_cache_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  localparam int CELL_NUM_DEF   = 1200;
  localparam int CELL_WIDTH_DEF = 768;
  localparam int STALL_CNT_W    = 16;

endpackage

// File: rtl/cell_cache_arb_if.sv
// Handshake/bus bundle between cell cache arbiter and its users.
// slave = arbiter side, master = buffer/requester/RAM side.
import cell_cache_pkg::*;

interface cell_cache_arb_if #(
  parameter int CELL_NUM = CELL_NUM_DEF,
  parameter int REQ_NUM  = 2
);
  localparam int AW = $clog2(CELL_NUM);

  logic                  bwr_valid_i;
  logic                  bwr_ready_o;
  logic                  cache_wr_en_o;
  logic [AW-1:0]         cache_wr_addr_o;
  logic [REQ_NUM-1:0]    req_valid_i;
  logic [REQ_NUM*AW-1:0] req_addr_i;
  logic [REQ_NUM-1:0]    req_ready_o;
  logic                  cache_rd_en_o;
  logic [AW-1:0]         cache_rd_addr_o;
  logic [REQ_NUM-1:0]    rsp_valid_o;
  logic [REQ_NUM-1:0]    frame_release_i;
  logic                  frame_full_o;

  modport slave (
    input  bwr_valid_i,
    output bwr_ready_o,
    output cache_wr_en_o,
    output cache_wr_addr_o,
    input  req_valid_i,
    input  req_addr_i,
    output req_ready_o,
    output cache_rd_en_o,
    output cache_rd_addr_o,
    output rsp_valid_o,
    input  frame_release_i,
    output frame_full_o
  );

  modport master (
    output bwr_valid_i,
    input  bwr_ready_o,
    input  cache_wr_en_o,
    input  cache_wr_addr_o,
    output req_valid_i,
    output req_addr_i,
    input  req_ready_o,
    input  cache_rd_en_o,
    input  cache_rd_addr_o,
    input  rsp_valid_o,
    output frame_release_i,
    input  frame_full_o
  );

endinterface

// File: rtl/cell_cache_arb_rr_arbiter.sv
// Combinational round-robin picker; search starts at ptr_i.
// Pointer register lives in the parent.
import cell_cache_pkg::*;

module rr_arbiter #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_any_o
);

  // first eligible requester at or after the pointer, wrapping
  always_comb begin
    int  j;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!found && elig_i[j]) begin
        found     = 1'b1;
        gnt_idx_o = W'(j);
        gnt_o[j]  = 1'b1;
      end
    end
    gnt_any_o = found;
  end

endmodule

// File: rtl/cell_cache_arb.sv
// Cell cache sequencer: in-order fill, round-robin read sharing.
// Optional CELL_CACHE_ARB_STALL_CNT_EN adds stall_cnt_o counters.
import cell_cache_pkg::*;

module cell_cache_arb #(
  parameter int CELL_NUM    = CELL_NUM_DEF,
  parameter int REQ_NUM     = 2,
  parameter int CELL_ADDR_W = $clog2(CELL_NUM),
  parameter int REQ_W       = $clog2(REQ_NUM)
) (
  input  logic clk,
  input  logic rst,
  cell_cache_arb_if.slave bus
`ifdef CELL_CACHE_ARB_STALL_CNT_EN
  ,
  output logic [REQ_NUM*STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int CW = CELL_ADDR_W + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      wr_cnt_q, wr_cnt_d;
  logic [REQ_NUM-1:0] rel_mask_q, rel_mask_d;
  logic [REQ_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [REQ_NUM-1:0] rsp_valid_q;

  logic [CELL_ADDR_W-1:0] addr [REQ_NUM];
  logic [REQ_NUM-1:0]     elig;
  logic [REQ_NUM-1:0]     gnt;
  logic [REQ_W-1:0]       gnt_idx;
  logic                   gnt_any;
  logic                   wr_en;
  logic                   frame_done;
  logic [REQ_NUM-1:0]     rel_set;

  // per-requester address slice and eligibility
  for (genvar k = 0; k < REQ_NUM; k++) begin : g_req
    logic [CW-1:0] ax;
    assign addr[k] =
      bus.req_addr_i[k*CELL_ADDR_W +: CELL_ADDR_W];
    assign ax = {1'b0, addr[k]};
    assign elig[k] = bus.req_valid_i[k]
      && (ax < CW'(CELL_NUM))
      && ((state_q == ST_FILL) ? (ax < wr_cnt_q)
                               : !rel_mask_q[k]);
  end

  rr_arbiter #(
    .N (REQ_NUM),
    .W (REQ_W)
  ) u_arb (
    .elig_i    (elig),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign wr_en = bus.bwr_valid_i && (state_q == ST_FILL);

  assign rel_set = rel_mask_q
    | ((state_q == ST_FULL) ? bus.frame_release_i : '0);
  assign frame_done = (state_q == ST_FULL) && (&rel_set);

  // next state: fill counting, release collection, rr pointer
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rel_mask_d = rel_mask_q;
    rr_ptr_d   = rr_ptr_q;
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
      if (wr_cnt_q == CW'(CELL_NUM - 1))
        state_d = ST_FULL;
    end
    if (frame_done) begin
      state_d    = ST_FILL;
      wr_cnt_d   = '0;
      rel_mask_d = '0;
    end else if (state_q == ST_FULL) begin
      rel_mask_d = rel_set;
    end
    if (gnt_any) begin
      if (gnt_idx == REQ_W'(REQ_NUM - 1))
        rr_ptr_d = '0;
      else
        rr_ptr_d = gnt_idx + REQ_W'(1);
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_cnt_q    <= '0;
      rel_mask_q  <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rel_mask_q  <= rel_mask_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= gnt;
    end
  end

  assign bus.bwr_ready_o     = (state_q == ST_FILL);
  assign bus.cache_wr_en_o   = wr_en;
  assign bus.cache_wr_addr_o = wr_cnt_q[CELL_ADDR_W-1:0];
  assign bus.req_ready_o     = gnt;
  assign bus.cache_rd_en_o   = gnt_any;
  assign bus.cache_rd_addr_o = addr[gnt_idx];
  assign bus.rsp_valid_o     = rsp_valid_q;
  assign bus.frame_full_o    = (state_q == ST_FULL);

`ifdef CELL_CACHE_ARB_STALL_CNT_EN
  for (genvar k = 0; k < REQ_NUM; k++) begin : g_stall
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    // count waiting cycles, saturating, cleared per frame
    always_comb begin
      cnt_d = cnt_q;
      if (frame_done)
        cnt_d = '0;
      else if (bus.req_valid_i[k] && !gnt[k]
               && (cnt_q != '1))
        cnt_d = cnt_q + STALL_CNT_W'(1);
    end

    // stall counter register
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign stall_cnt_o[k*STALL_CNT_W +: STALL_CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_cell_cache_arb.sv
// Directed bench for cell_cache_arb (1200 cells, 2 requesters).
// Expected values are hand-derived per cycle.
module tb_cell_cache_arb;

  localparam int CN = 1200;
  localparam int RN = 2;
  localparam int AW = $clog2(CN);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cell_cache_arb_if #(.CELL_NUM(CN), .REQ_NUM(RN)) bus();

`ifdef CELL_CACHE_ARB_STALL_CNT_EN
  logic [RN*16-1:0] stall_cnt;
`endif

  cell_cache_arb #(
    .CELL_NUM (CN),
    .REQ_NUM  (RN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CELL_CACHE_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v,
                         input int a0, input int a1);
    bus.req_valid_i = v;
    bus.req_addr_i  = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    logic [1:0] eg;
    logic [1:0] pv;
    bus.bwr_valid_i     = 1'b0;
    bus.req_valid_i     = '0;
    bus.req_addr_i      = '0;
    bus.frame_release_i = '0;
    nxt();
    nxt();
    rst = 1'b0;
    #1;
    check("rst_bwr_ready", 64'(bus.bwr_ready_o), 1);
    check("rst_full", 64'(bus.frame_full_o), 0);
    check("rst_rsp", 64'(bus.rsp_valid_o), 0);
    check("rst_wr_addr", 64'(bus.cache_wr_addr_o), 0);
    check("rst_req_ready", 64'(bus.req_ready_o), 0);
`ifdef CELL_CACHE_ARB_STALL_CNT_EN
    check("rst_stall", 64'(stall_cnt), 0);
`endif
    nxt();

    // write cells 0..4
    bus.bwr_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("fill_addr", 64'(bus.cache_wr_addr_o), 64'(i));
      check("fill_en", 64'(bus.cache_wr_en_o), 1);
      nxt();
    end

    // wr_cnt=5: req0@5 hazard, req1@2 ok
    set_req(2'b11, 5, 2);
    #1;
    check("hz_gnt", 64'(bus.req_ready_o), 2);
    check("hz_rd_en", 64'(bus.cache_rd_en_o), 1);
    check("hz_rd_addr", 64'(bus.cache_rd_addr_o), 2);
    check("hz_wr_addr", 64'(bus.cache_wr_addr_o), 5);
    nxt();
    bus.bwr_valid_i = 1'b0;
    set_req(2'b01, 5, 2);
    #1;
    check("hz1_rsp", 64'(bus.rsp_valid_o), 2);
    check("hz1_gnt", 64'(bus.req_ready_o), 1);
    check("hz1_rd_addr", 64'(bus.cache_rd_addr_o), 5);
    nxt();
    set_req(2'b00, 0, 0);
    #1;
    check("hz2_rsp", 64'(bus.rsp_valid_o), 1);
    check("hz2_gnt", 64'(bus.req_ready_o), 0);
    check("hz2_rd_en", 64'(bus.cache_rd_en_o), 0);
    nxt();

    // req1 asks for addr 6 == wr_cnt: stalls 10 cycles
    set_req(2'b10, 0, 6);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_gnt", 64'(bus.req_ready_o), 0);
      nxt();
    end
    set_req(2'b00, 0, 0);
    #1;
`ifdef CELL_CACHE_ARB_STALL_CNT_EN
    check("stall_cnt1", 64'(stall_cnt[31:16]), 10);
    check("stall_cnt0", 64'(stall_cnt[15:0]), 1);
`endif
    nxt();

    // write remaining cells 6..1199
    bus.bwr_valid_i = 1'b1;
    for (int k = 6; k < CN; k++) begin
      #1;
      check("fill_addr", 64'(bus.cache_wr_addr_o), 64'(k));
      nxt();
    end
    #1;
    check("full_flag", 64'(bus.frame_full_o), 1);
    check("full_bwr_ready", 64'(bus.bwr_ready_o), 0);
    check("full_wr_en", 64'(bus.cache_wr_en_o), 0);
    bus.bwr_valid_i = 1'b0;
    nxt();

    // out-of-range req0 never granted
    set_req(2'b11, 1200, 10);
    #1;
    check("oor_gnt", 64'(bus.req_ready_o), 2);
    check("oor_rd_addr", 64'(bus.cache_rd_addr_o), 10);
    nxt();
    set_req(2'b01, 1200, 10);
    #1;
    check("oor_alone", 64'(bus.req_ready_o), 0);
    check("oor_rsp", 64'(bus.rsp_valid_o), 2);
    nxt();

    // alternation with last valid address 1199
    set_req(2'b11, 1199, 0);
    eg = 2'b01;
    pv = 2'b00;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_gnt", 64'(bus.req_ready_o), 64'(eg));
      check("rr_rsp", 64'(bus.rsp_valid_o), 64'(pv));
      check("rr_rd_addr", 64'(bus.cache_rd_addr_o),
            (eg == 2'b01) ? 64'd1199 : 64'd0);
      pv = eg;
      eg = {eg[0], eg[1]};
      nxt();
    end
    set_req(2'b00, 0, 0);
    #1;
    check("rr_rsp_last", 64'(bus.rsp_valid_o), 64'(pv));
    nxt();

    // release 0 at t, release 1 at t+3
    set_req(2'b11, 3, 4);
    bus.frame_release_i = 2'b01;
    #1;
    check("rel_t_gnt", 64'(bus.req_ready_o), 1);
    check("rel_t_full", 64'(bus.frame_full_o), 1);
    nxt();
    bus.frame_release_i = 2'b00;
    #1;
    check("rel_t1_gnt", 64'(bus.req_ready_o), 2);
    nxt();
    #1;
    check("rel_t2_gnt", 64'(bus.req_ready_o), 2);
    nxt();
    bus.frame_release_i = 2'b10;
    #1;
    check("rel_t3_gnt", 64'(bus.req_ready_o), 2);
    check("rel_t3_bwr", 64'(bus.bwr_ready_o), 0);
    nxt();
    bus.frame_release_i = 2'b00;
    #1;
    check("rel_t4_bwr", 64'(bus.bwr_ready_o), 1);
    check("rel_t4_full", 64'(bus.frame_full_o), 0);
    check("rel_t4_wr_addr", 64'(bus.cache_wr_addr_o), 0);
    check("rel_t4_gnt", 64'(bus.req_ready_o), 0);
    check("rel_t4_rsp", 64'(bus.rsp_valid_o), 2);
`ifdef CELL_CACHE_ARB_STALL_CNT_EN
    check("rel_t4_stall", 64'(stall_cnt), 0);
`endif
    nxt();

    // fill 700 cells, then reset with a grant
    set_req(2'b00, 0, 0);
    bus.bwr_valid_i = 1'b1;
    repeat (700) nxt();
    #1;
    check("mid_wr_addr", 64'(bus.cache_wr_addr_o), 700);
    set_req(2'b01, 100, 0);
    rst = 1'b1;
    #1;
    check("mid_gnt", 64'(bus.req_ready_o), 1);
    nxt();
    rst = 1'b0;
    bus.bwr_valid_i = 1'b0;
    set_req(2'b00, 0, 0);
    #1;
    check("mrst_wr_addr", 64'(bus.cache_wr_addr_o), 0);
    check("mrst_rsp", 64'(bus.rsp_valid_o), 0);
    check("mrst_full", 64'(bus.frame_full_o), 0);
    check("mrst_ptr", 64'(dut.rr_ptr_q), 0);
    check("mrst_bwr", 64'(bus.bwr_ready_o), 1);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
